// File: rtl/interrupt_dispatch_controller.sv
// rtl/interrupt_dispatch_controller.sv - interrupt request/ISR entry-exit sequencer
// Optional source-ID capture enabled by defining INTERRUPT_DISPATCH_SRC_ID_EN.
module interrupt_dispatch_controller #(
    parameter int          PIR_WIDTH   = 8,
    parameter logic [12:0] VECTOR_ADDR = 13'h0004
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           intcon_q,
    input  logic [PIR_WIDTH-1:0] pir_q,
    input  logic [PIR_WIDTH-1:0] pie_q,
    input  logic                 int_ack,
    input  logic                 retfie_exec,
    output logic                 int_req,
    output logic                 vector_load,
    output logic [12:0]          vector_addr,
    output logic                 gie_clr,
    output logic                 gie_set,
    output logic                 in_isr,
    output logic                 wake
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
    ,
    output logic [3:0]           src_id,
    output logic                 src_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ENTRY = 2'd2,
        ISR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic int_req_q, int_req_d;
    logic vector_load_q, vector_load_d;
    logic gie_clr_q, gie_clr_d;
    logic gie_set_q, gie_set_d;
    logic in_isr_q, in_isr_d;
    logic wake_q;

    logic                 intf_pend;
    logic                 t0if_pend;
    logic                 rbif_pend;
    logic [PIR_WIDTH-1:0] periph_flags;
    logic                 core_pend;
    logic                 periph_pend;
    logic                 any_pend;
    logic                 fire;

    assign intf_pend    = intcon_q[4] & intcon_q[1];
    assign t0if_pend    = intcon_q[5] & intcon_q[2];
    assign rbif_pend    = intcon_q[3] & intcon_q[0];
    assign periph_flags = pir_q & pie_q;
    assign core_pend    = intf_pend | t0if_pend | rbif_pend;
    assign periph_pend  = intcon_q[6] & (|periph_flags);
    assign any_pend     = core_pend | periph_pend;
    assign fire         = intcon_q[7] & any_pend;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Acknowledge beats a same-cycle withdrawal: the core has already committed.
                if (int_ack) begin
                    state_d = ENTRY;
                end else if (!fire) begin
                    state_d = IDLE;
                end
            end
            ENTRY: begin
                state_d = ISR;
            end
            ISR: begin
                if (retfie_exec) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        int_req_d     = (state_d == REQ);
        vector_load_d = (state_d == ENTRY);
        gie_clr_d     = (state_d == ENTRY);
        in_isr_d      = (state_d == ENTRY) || (state_d == ISR);
        // A stray RETFIE colliding with entry must not fight the GIE clear.
        gie_set_d     = retfie_exec && (state_d != ENTRY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            int_req_q     <= 1'b0;
            vector_load_q <= 1'b0;
            gie_clr_q     <= 1'b0;
            gie_set_q     <= 1'b0;
            in_isr_q      <= 1'b0;
            wake_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_req_q     <= int_req_d;
            vector_load_q <= vector_load_d;
            gie_clr_q     <= gie_clr_d;
            gie_set_q     <= gie_set_d;
            in_isr_q      <= in_isr_d;
            wake_q        <= any_pend;
        end
    end

    assign int_req     = int_req_q;
    assign vector_load = vector_load_q;
    assign vector_addr = VECTOR_ADDR;
    assign gie_clr     = gie_clr_q;
    assign gie_set     = gie_set_q;
    assign in_isr      = in_isr_q;
    assign wake        = wake_q;

`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
    logic [3:0] src_sel;
    logic [3:0] src_id_q;
    logic       src_valid_q;

    always_comb begin
        src_sel = 4'd0;
        if (intf_pend) begin
            src_sel = 4'd0;
        end else if (t0if_pend) begin
            src_sel = 4'd1;
        end else if (rbif_pend) begin
            src_sel = 4'd2;
        end else begin
            // Descending scan so the lowest set bit is the one that sticks.
            for (int i = PIR_WIDTH - 1; i >= 0; i--) begin
                if (periph_flags[i]) begin
                    src_sel = 4'(i + 3);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_id_q    <= 4'd0;
            src_valid_q <= 1'b0;
        end else begin
            src_valid_q <= in_isr_d;
            if (state_q == REQ && state_d == ENTRY) begin
                src_id_q <= src_sel;
            end
        end
    end

    assign src_id    = src_id_q;
    assign src_valid = src_valid_q;
`endif

endmodule

// File: tb/tb_interrupt_dispatch_controller.sv
// tb/tb_interrupt_dispatch_controller.sv - directed self-checking bench for interrupt_dispatch_controller
module tb_interrupt_dispatch_controller;

    logic        clk;
    logic        rst;
    logic [7:0]  intcon_q;
    logic [7:0]  pir_q;
    logic [7:0]  pie_q;
    logic        int_ack;
    logic        retfie_exec;
    logic        int_req;
    logic        vector_load;
    logic [12:0] vector_addr;
    logic        gie_clr;
    logic        gie_set;
    logic        in_isr;
    logic        wake;
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
    logic [3:0]  src_id;
    logic        src_valid;
`endif

    int checks;
    int fails;

    interrupt_dispatch_controller #(
        .PIR_WIDTH  (8),
        .VECTOR_ADDR(13'h0004)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .intcon_q   (intcon_q),
        .pir_q      (pir_q),
        .pie_q      (pie_q),
        .int_ack    (int_ack),
        .retfie_exec(retfie_exec),
        .int_req    (int_req),
        .vector_load(vector_load),
        .vector_addr(vector_addr),
        .gie_clr    (gie_clr),
        .gie_set    (gie_set),
        .in_isr     (in_isr),
        .wake       (wake)
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
        ,
        .src_id     (src_id),
        .src_valid  (src_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic vl,
                              input logic gc, input logic gs, input logic isr);
        check({tag, ".int_req"}, 16'(int_req), 16'(req));
        check({tag, ".vector_load"}, 16'(vector_load), 16'(vl));
        check({tag, ".gie_clr"}, 16'(gie_clr), 16'(gc));
        check({tag, ".gie_set"}, 16'(gie_set), 16'(gs));
        check({tag, ".in_isr"}, 16'(in_isr), 16'(isr));
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        rst         = 1'b1;
        intcon_q    = 8'h00;
        pir_q       = 8'h00;
        pie_q       = 8'h00;
        int_ack     = 1'b0;
        retfie_exec = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.wake", 16'(wake), 16'h0);
        check("vector_addr", 16'(vector_addr), 16'h0004);

        // Peripheral request path
        intcon_q = 8'hC0;
        pie_q    = 8'h01;
        tick();
        check("no_flag.int_req", 16'(int_req), 16'h0);
        pir_q = 8'h01;
        tick();
        check("req_rise.int_req", 16'(int_req), 16'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("req_hold.int_req", 16'(int_req), 16'h1);
        end

        // Entry handshake
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_outs("entry", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        intcon_q = 8'h40;
        check_outs("isr1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("isr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // RETFIE with flag still pending: blackout then re-request
        retfie_exec = 1'b1;
        tick();
        retfie_exec = 1'b0;
        check_outs("retfie", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        intcon_q = 8'hC0;
        check_outs("blackout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("reentry.int_req", 16'(int_req), 16'h1);

        // Withdrawal in REQ when GIE is cleared
        intcon_q = 8'h40;
        tick();
        check_outs("withdraw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        intcon_q = 8'hC0;
        tick();
        check("req_again.int_req", 16'(int_req), 16'h1);

        // Same-cycle ack and withdrawal: ack wins
        intcon_q = 8'h40;
        int_ack  = 1'b1;
        tick();
        int_ack = 1'b0;
        check_outs("ack_wins", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("ack_wins_isr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pir_q       = 8'h00;
        retfie_exec = 1'b1;
        tick();
        retfie_exec = 1'b0;
        check_outs("retfie2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Wake independent of GIE
        intcon_q = 8'h12;
        pir_q    = 8'h00;
        pie_q    = 8'h00;
        tick();
        check("wake_core.wake", 16'(wake), 16'h1);
        check("wake_core.int_req", 16'(int_req), 16'h0);
        intcon_q = 8'h00;
        pir_q    = 8'h02;
        pie_q    = 8'h02;
        tick();
        check("wake_nopeie.wake", 16'(wake), 16'h0);
        intcon_q = 8'h40;
        tick();
        check("wake_peie.wake", 16'(wake), 16'h1);
        check("wake_peie.int_req", 16'(int_req), 16'h0);

        // RETFIE and int_ack outside their states
        retfie_exec = 1'b1;
        tick();
        retfie_exec = 1'b0;
        check_outs("stray_retfie", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_outs("stray_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // INTF and pir bit 2 pending together at acknowledge
        intcon_q = 8'hD2;
        pir_q    = 8'h04;
        pie_q    = 8'h04;
        tick();
        check("src0_req.int_req", 16'(int_req), 16'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_outs("src0_entry", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
        check("src0.src_id", 16'(src_id), 16'h0);
        check("src0.src_valid", 16'(src_valid), 16'h1);
`endif
        intcon_q = 8'h52;
        tick();
        check("src0_isr.in_isr", 16'(in_isr), 16'h1);

        // Reset in the middle of the ISR
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("rst_isr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_isr.wake", 16'(wake), 16'h0);
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
        check("rst_isr.src_id", 16'(src_id), 16'h0);
        check("rst_isr.src_valid", 16'(src_valid), 16'h0);
`endif

        // Next entry with INTF clear: peripheral bit 2 wins
        intcon_q = 8'hC0;
        tick();
        check("src5_req.int_req", 16'(int_req), 16'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_outs("src5_entry", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("src5_entry.wake", 16'(wake), 16'h1);
`ifdef INTERRUPT_DISPATCH_SRC_ID_EN
        check("src5.src_id", 16'(src_id), 16'h5);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_dispatch_controller.md
Name: interrupt_dispatch_controller

Overview:
- Consumer side of the peripheral interrupt flag registers: combines the INTCON, PIR and PIE contents into one interrupt request to the CPU core.
- Sequences ISR entry and exit through a request/acknowledge handshake with the core's instruction-boundary logic.
- Emits GIE clear/set strobes and vector-load strobes, plus a sleep wake signal.
- Sits between the special-function register file and the core control unit.

Parameters:
- PIR_WIDTH, 8, width of the peripheral flag and enable vectors
- VECTOR_ADDR, 13'h0004, program address presented on ISR entry

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- intcon_q  in  8  INTCON contents: [7]=GIE, [6]=PEIE, [5:3]=T0IE/INTE/RBIE, [2:0]=T0IF/INTF/RBIF
- pir_q  in  PIR_WIDTH  peripheral flags, as read by the CPU
- pie_q  in  PIR_WIDTH  peripheral enables
- int_ack  in  1  core pulse: request accepted at instruction boundary
- retfie_exec  in  1  core pulse: RETFIE executing
- int_req  out  1  interrupt request to core
- vector_load  out  1  one-cycle strobe: load PC with vector_addr
- vector_addr  out  13  constant VECTOR_ADDR
- gie_clr  out  1  one-cycle strobe to INTCON: clear GIE
- gie_set  out  1  one-cycle strobe to INTCON: set GIE
- in_isr  out  1  high from ENTRY until RETFIE accepted
- wake  out  1  sleep wake request

Behaviour:
- Combinational terms:
  - core_pend = |(intcon_q[5:3] & intcon_q[2:0])
  - periph_pend = intcon_q[6] & |(pir_q & pie_q)
  - any_pend = core_pend | periph_pend
  - fire = intcon_q[7] & any_pend
- All outputs are registered except vector_addr.
- Reset: state=IDLE; int_req, vector_load, gie_clr, gie_set, in_isr and wake are all 0. Reset takes effect in any state and abandons any handshake in progress, including mid-ENTRY and mid-ISR.
- States (2-bit):
  - IDLE: if fire, go to REQ; int_req goes high on the following edge (1-cycle latency from the flag).
  - REQ: int_req=1.
    - If int_ack, go to ENTRY.
    - Else if !fire (software cleared GIE, or the flag/enable dropped), go to IDLE and drop int_req.
    - If int_ack and !fire occur in the same cycle, int_ack wins.
  - ENTRY: lasts exactly 1 cycle. vector_load=1, gie_clr=1, int_req=0, in_isr=1. Then go to ISR.
  - ISR: in_isr=1 and int_req=0; no nesting, and new flags stay pending. On retfie_exec, pulse gie_set for 1 cycle and go to IDLE; in_isr clears on the same edge.
- Re-entry after RETFIE:
  - IDLE sees GIE=1 one cycle after the gie_set pulse.
  - If a flag is still set, the earliest int_req is 2 cycles after the RETFIE pulse. This gives a one-cycle blackout, and back-to-back entry is permitted.
- retfie_exec outside ISR: still pulse gie_set, matching RETFIE semantics. State is unchanged.
- int_ack outside REQ is ignored.
- wake = any_pend registered, with 1-cycle latency and independent of GIE. A peripheral source wakes only with PEIE=1.
- gie_clr and gie_set are never asserted in the same cycle. ENTRY and ISR are exclusive.

Optional Feature:
- Macro: INTERRUPT_DISPATCH_SRC_ID_EN
- Defined: adds output src_id [3:0] and output src_valid.
  - Captured on the REQ->ENTRY transition, with priority INTF=0, T0IF=1, RBIF=2, then the lowest set pir_q&pie_q bit = 3+index.
  - src_valid is high while in_isr.
  - Both reset to 0 and hold until the next ENTRY.
- Undefined: no src_id/src_valid ports and no capture logic. Core behaviour is identical.

Test Plan:
- Reset, then GIE=1, PEIE=1, pie_q=8'h01, pir_q 0->8'h01 -> int_req=1 one cycle later. Hold int_ack=0 for 5 cycles -> int_req stays 1.
- From REQ, pulse int_ack -> next cycle vector_load=1, gie_clr=1, vector_addr=13'h0004, in_isr=1 for exactly 1 cycle. in_isr stays 1, int_req=0.
- In ISR, pulse retfie_exec with pir_q=8'h01 still set -> gie_set one-cycle pulse, in_isr=0, int_req=1 two cycles after retfie.
- In REQ, clear GIE (intcon_q=8'h40) with int_ack=0 -> int_req drops next cycle, state IDLE. Repeat with int_ack=1 on the same cycle -> ENTRY taken.
- GIE=0, INTE=1, INTF=1 -> wake=1 after 1 cycle, int_req stays 0. Same with PEIE=0 and pir/pie=8'h02 -> wake=0.
- Assert rst during ISR -> next cycle all outputs 0. With INTERRUPT_DISPATCH_SRC_ID_EN, INTF and pir bit 2 both pending at ack -> src_id=0. Next entry with INTF clear -> src_id=5.
